univ_shift_register: RTL
========================

# univ_shift_register

Parametrised universal shift register: the next generation of the team's 4-bit serial-in/serial-out shift register. It adds configurable width, left/right shift, parallel load and hold, parallel readout, and a shift counter with a frame-complete pulse. It sits between serial links and parallel datapaths as a serialiser or deserialiser.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when low, all state holds.
- mode  input  2  operation: 00 HOLD, 01 SHL (shift toward MSB), 10 SHR (shift toward LSB), 11 LOAD.
- ser_in_l  input  1  bit entering at bit 0 on SHL.
- ser_in_r  input  1  bit entering at bit WIDTH-1 on SHR.
- par_in  input  WIDTH  parallel load data.
- rotate  input  1  present only when SHIFT_REG_ROTATE_EN is defined; see Configuration.
- par_out  output  WIDTH  register contents.
- ser_out_l  output  1  equals par_out[WIDTH-1].
- ser_out_r  output  1  equals par_out[0].
- shift_cnt  output  $clog2(WIDTH+1)  number of shifts since the last LOAD, reset or wrap.
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

## Operation
- Reset (reset=1 at a clk edge) overrides en and mode. par_out=0, shift_cnt=0, frame_done=0. The serial outputs therefore read 0.
- en=0: par_out and shift_cnt hold; frame_done=0.
- en=1 behaves according to mode:
  - HOLD: no change; frame_done=0.
  - SHL: par_out <= {par_out[WIDTH-2:0], ser_in_l}.
  - SHR: par_out <= {ser_in_r, par_out[WIDTH-1:1]}.
  - LOAD: par_out <= par_in; shift_cnt <= 0; frame_done=0.
- Counter: each SHL or SHR increments shift_cnt. When the incremented value would equal WIDTH, shift_cnt wraps to 0 and frame_done is 1 for that one cycle. Otherwise frame_done is 0.
- Direction changes mid-frame still count as shifts. The counter does not track direction.
- LOAD mid-frame discards the partial count. No frame_done is produced for the abandoned frame.
- The counter never exceeds WIDTH-1 on the output.

## Timing
- par_out, shift_cnt and frame_done are registered. They update on the clk edge where en=1, with one cycle of latency from the inputs.
- ser_out_l and ser_out_r are combinational taps of the register, adding zero extra latency.
- frame_done rises in the same cycle that par_out shows the result of the WIDTH-th shift. It is low in the next cycle unless another frame completes then, which requires WIDTH=... and is impossible because WIDTH≥2.
- When en is low on a cycle, that cycle counts as neither a shift nor a hold. The frame simply resumes when en returns high.
- If reset asserts mid-frame, all state is zero on the next cycle. Counting restarts from 0.

## Configuration
- SHIFT_REG_ROTATE_EN defined:
  - The rotate input exists.
  - With rotate=1, SHL feeds par_out[WIDTH-1] into bit 0 and SHR feeds par_out[0] into bit WIDTH-1, ignoring ser_in_l and ser_in_r.
  - Rotations count as shifts and drive frame_done.
  - With rotate=0, behaviour is identical to the undefined build.
- SHIFT_REG_ROTATE_EN undefined: the rotate port is absent. Shifts always take serial inputs.

## Structure
- Shared package shift_reg_pkg holds:
  - the mode typedef (2-bit enum MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD);
  - a function returning the shift_cnt width for a given WIDTH.
- One sub-module, shift_frame_counter, is natural. It takes WIDTH, reset, en, a shift strobe and a clear strobe. It outputs shift_cnt and frame_done, and owns the wrap logic.

## Test plan
- Reset and zero state: assert reset for 2 cycles with en=1, mode=LOAD, par_in=8'hFF. Require par_out=0, shift_cnt=0, frame_done=0.
- Serialise MSB-first: LOAD 8'hA5, then 8× SHL with ser_in_l=0. Require ser_out_l to read 1,0,1,0,0,1,0,1 (the bit shown before each shift), par_out=0 at the end, and frame_done high only after the 8th shift with shift_cnt back to 0.
- Deserialise right: with par_out=0, apply 8× SHR with ser_in_r sequence 1,1,0,0,1,0,1,0. Require par_out=8'h53 and a single frame_done pulse.
- Abort and stall: after LOAD 8'h0F, apply 3× SHL, then 2 cycles with en=0. Require par_out=8'h78 and shift_cnt=3 held. Then LOAD 8'h3C. Require shift_cnt=0 and no frame_done.
- Rotate (macro defined): LOAD 8'h81, then 8× SHL with rotate=1. Require par_out to sequence 03,06,0C,18,30,60,C0,81 and frame_done on the last rotation.
- Reset mid-frame: apply 5× SHR, then reset for 1 cycle. Require par_out=0 and shift_cnt=0. Then 8 more shifts must produce frame_done exactly once.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encoding and counter-width helper for the universal shift register
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_register_if.sv
// rtl/univ_shift_register_if.sv - control/data bundle for univ_shift_register (rotate present under SHIFT_REG_ROTATE_EN)
interface univ_shift_register_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic             en;
  mode_t            mode;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] par_in;
`ifdef SHIFT_REG_ROTATE_EN
  logic             rotate;
`endif
  logic [WIDTH-1:0] par_out;
  logic             ser_out_l;
  logic             ser_out_r;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

  modport master (
    output en, mode, ser_in_l, ser_in_r, par_in,
`ifdef SHIFT_REG_ROTATE_EN
    output rotate,
`endif
    input  par_out, ser_out_l, ser_out_r, shift_cnt, frame_done
  );

  modport slave (
    input  en, mode, ser_in_l, ser_in_r, par_in,
`ifdef SHIFT_REG_ROTATE_EN
    input  rotate,
`endif
    output par_out, ser_out_l, ser_out_r, shift_cnt, frame_done
  );

endinterface

// File: rtl/shift_frame_counter.sv
// rtl/shift_frame_counter.sv - counts shifts per frame, wraps at WIDTH and pulses frame_done on the wrap
module shift_frame_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             shift,
  input  logic             clear,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic             done;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (clear) begin
        cnt  <= '0;
        done <= 1'b0;
      end else if (shift) begin
        // the WIDTH-th shift wraps the count instead of showing WIDTH
        if (cnt == LAST) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          done <= 1'b0;
        end
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign shift_cnt  = cnt;
  assign frame_done = done;

endmodule

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - universal shift register with load/hold/shift and frame counter; SHIFT_REG_ROTATE_EN adds rotation
module univ_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  univ_shift_register_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             fill_l;
  logic             fill_r;

  always_comb begin
    fill_l = bus.ser_in_l;
    fill_r = bus.ser_in_r;
`ifdef SHIFT_REG_ROTATE_EN
    if (bus.rotate) begin
      fill_l = q[WIDTH-1];
      fill_r = q[0];
    end
`endif
    q_next = q;
    case (bus.mode)
      MODE_SHL:  q_next = {q[WIDTH-2:0], fill_l};
      MODE_SHR:  q_next = {fill_r, q[WIDTH-1:1]};
      MODE_LOAD: q_next = bus.par_in;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (bus.en) begin
      q <= q_next;
    end
  end

  assign bus.par_out   = q;
  assign bus.ser_out_l = q[WIDTH-1];
  assign bus.ser_out_r = q[0];

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .en         (bus.en),
    .shift      ((bus.mode == MODE_SHL) || (bus.mode == MODE_SHR)),
    .clear      (bus.mode == MODE_LOAD),
    .shift_cnt  (bus.shift_cnt),
    .frame_done (bus.frame_done)
  );

endmodule
